alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one 32-bit yAlu instance between two requesters (port 0, port 1).
//  Arbitrates, latches operands, runs the op, then holds the registered result
//  until the winning requester accepts it. One operation in flight at a time.
//  Sits between the issue logic of two execution lanes and the shared ALU.
// PARAMETERS
//  FIXED_PRIO  0  0 = round-robin between ports; 1 = port 0 always wins a tie
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  req0_valid    in   1   port 0 has an operation
//  req0_ready    out  1   port 0 operation accepted this cycle
//  req0_a        in   32  port 0 operand a
//  req0_b        in   32  port 0 operand b
//  req0_op       in   3   port 0 ALU op (000 and,001 or,010 add,110 sub,111 slt)
//  req1_valid    in   1   port 1 has an operation
//  req1_ready    out  1   port 1 operation accepted this cycle
//  req1_a/_b     in   32  port 1 operands a, b
//  req1_op       in   3   port 1 ALU op
//  rsp_valid     out  1   result held on rsp_z/rsp_zero
//  rsp_port      out  1   port that owns the current result
//  rsp_ready     in   1   owning port accepts the result
//  rsp_z         out  32  registered ALU result
//  rsp_zero      out  1   registered ALU ex (result==0) flag
//  busy          out  1   high in EXEC or RESP
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_port=0, rsp_z=0, rsp_zero=0,
//   busy=0, both req*_ready=0; operand/op registers cleared to 0.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: req*_ready is combinational, asserted only in IDLE for the grant winner.
//   Only one valid: that port wins. Both valid: FIXED_PRIO=1 -> port 0;
//   else port rr_ptr wins. On grant: latch a,b,op, owner<=winner, go EXEC.
//   rr_ptr <= ~winner on every grant (round-robin only). No valid: stay IDLE.
//  EXEC (1 cycle): yAlu fed from latched regs; at clock edge rsp_z<=z,
//   rsp_zero<=ex, rsp_port<=owner, rsp_valid<=1, go RESP.
//  RESP: outputs stable; rsp_ready=1 -> rsp_valid<=0, go IDLE. Else hold.
//  Latency: grant edge T -> rsp_valid high for cycle T+2; next grant no
//   earlier than the cycle after rsp handshake (max throughput 1 op / 3 cyc).
//  req*_ready never asserted outside IDLE; requests wait with valid held.
//  Op codes not listed (011,100,101) pass through to yAlu unchanged; result is
//   whatever yAlu produces (e.g. 011 = slt without subtract setup); not an error.
//  Arithmetic: 32-bit wrap-around, no overflow flag; slt is signed.
//  reset asserted in any state: abandons in-flight op, no response issued,
//   all outputs to reset values on the next edge.
//  rsp_ready ignored when rsp_valid=0.
// TESTING
//  1 Reset, port0 add a=5 b=7 -> ready0 at T, rsp_valid at T+2, z=12, zero=0, port=0
//  2 Port1 sub a=9 b=9 -> z=0, rsp_zero=1, rsp_port=1
//  3 Both valid continuously, RR: grants alternate 0,1,0,1; FIXED_PRIO=1: all 0
//  4 slt a=32'hFFFF_FFFF b=1 -> z=1; a=1 b=32'hFFFF_FFFF -> z=0; add
//    a=32'hFFFF_FFFF b=1 -> z=0, zero=1
//  5 rsp_ready held low 5 cycles -> rsp_z stable, req*_ready stay 0, busy=1
//  6 reset pulsed during EXEC -> no rsp_valid, all outputs 0, rr_ptr=0 after

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Arbitrated wrapper that time-shares one 32-bit ALU between two issue lanes.
// One operation in flight; the registered result is held until the owner accepts it.

module yalu (
  output logic [31:0] z,
  output logic        ex,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op
);
  logic [31:0] and_res;
  logic [31:0] or_res;
  logic [31:0] b_eff;
  logic [31:0] arith;
  logic [31:0] slt_res;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign and_res[gi] = a[gi] & b[gi];
      assign or_res[gi]  = a[gi] | b[gi];
      assign b_eff[gi]   = b[gi] ^ op[2];
    end
  endgenerate

  assign arith = a + b_eff + {31'd0, op[2]};

  // Differing signs: a's sign decides. Equal signs: the adder's sign bit,
  // which is a-b only when op[2] set up a subtract.
  assign slt_res = {31'd0, (a[31] ^ b[31]) ? a[31] : arith[31]};

  always_comb begin
    z = and_res;
    case (op[1:0])
      2'b00:   z = and_res;
      2'b01:   z = or_res;
      2'b10:   z = arith;
      default: z = slt_res;
    endcase
  end

  assign ex = (z == 32'd0);
endmodule

module alu_share_ctrl #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp_valid,
  output logic        rsp_port,
  input  logic        rsp_ready,
  output logic [31:0] rsp_z,
  output logic        rsp_zero,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg, state_next;
  logic        rr_ptr_reg;
  logic        owner_reg;
  logic [31:0] a_reg, b_reg;
  logic [2:0]  op_reg;
  logic        rsp_valid_reg, rsp_port_reg, rsp_zero_reg;
  logic [31:0] rsp_z_reg;
  logic        grant0, grant1;
  logic [31:0] alu_z;
  logic        alu_ex;

  yalu u_alu (
    .z  (alu_z),
    .ex (alu_ex),
    .a  (a_reg),
    .b  (b_reg),
    .op (op_reg)
  );

  always_comb begin
    state_next = state_reg;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Grants are suppressed while reset is high so nothing is accepted and lost.
        if (!reset) begin
          if (req0_valid && (!req1_valid || FIXED_PRIO != 0 || !rr_ptr_reg))
            grant0 = 1'b1;
          else if (req1_valid)
            grant1 = 1'b1;
        end
        if (grant0 || grant1)
          state_next = EXEC;
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= 1'b0;
      owner_reg     <= 1'b0;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      op_reg        <= 3'd0;
      rsp_valid_reg <= 1'b0;
      rsp_port_reg  <= 1'b0;
      rsp_z_reg     <= 32'd0;
      rsp_zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant0 || grant1) begin
            a_reg     <= grant1 ? req1_a  : req0_a;
            b_reg     <= grant1 ? req1_b  : req0_b;
            op_reg    <= grant1 ? req1_op : req0_op;
            owner_reg <= grant1;
            if (FIXED_PRIO == 0)
              rr_ptr_reg <= ~grant1;
          end
        end
        EXEC: begin
          rsp_z_reg     <= alu_z;
          rsp_zero_reg  <= alu_ex;
          rsp_port_reg  <= owner_reg;
          rsp_valid_reg <= 1'b1;
        end
        RESP: begin
          if (rsp_ready)
            rsp_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_port   = rsp_port_reg;
  assign rsp_z      = rsp_z_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign busy       = (state_reg != IDLE);
endmodule
